// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   state_e             : receiver FSM states
//   DATA_BITS           : payload bits per frame (8N1)
//   calc_clks_per_bit() : system clocks per serial bit
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk, rst_n : clock, asynchronous active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronised output (reset to reset_val)
module sync_2ff #(
  parameter logic reset_val = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its neighbours; = here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= reset_val;
      sync_q <= reset_val;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver feeding the hex display driver.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx         : asynchronous serial line, idles high
//   rx_byte    : last correctly framed byte, held until the next good frame
//   rx_valid   : one-cycle pulse on the cycle rx_byte updates
//   frame_err  : sticky bad-stop-bit flag, cleared by the next good frame
//   busy       : high whenever the receiver is not idle
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int sys_clk_freq = 100000000,
  parameter int baud_rate    = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int clks_per_bit = calc_clks_per_bit(sys_clk_freq, baud_rate);
  localparam int half_bit     = clks_per_bit / 2;
  localparam int CNT_W        = $clog2(clks_per_bit);
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(clks_per_bit - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  if (clks_per_bit < 8) begin : g_cfg_err
    $error("uart_rx_byte: clks_per_bit must be at least 8");
  end

  logic                 rx_s;
  state_e               state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [IDX_W-1:0]     bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [7:0]           rx_byte_q,   rx_byte_d;
  logic                 rx_valid_q,  rx_valid_d;
  logic                 frame_err_q, frame_err_d;

  // Reset value 1 matches the idle line, so reset release never looks like a start edge.
  sync_2ff #(.reset_val(1'b1)) u_rx_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; a missing default would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = frame_err_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end

      START: begin
        // Re-check the line mid start bit to reject short glitches; the
        // data samples then land mid-bit from here on.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == IDX_LAST) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end
      end

      STOP: begin
        // Sampled mid stop bit; returning to IDLE here leaves half a bit to
        // catch a back-to-back start edge.
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d     = IDLE;
            rx_byte_d   = shift_q;
            rx_valid_d  = 1'b1;
            frame_err_d = 1'b0;
          end else begin
            state_d     = WAIT_HIGH;
            frame_err_d = 1'b1;
          end
        end
      end

      WAIT_HIGH: begin
        // A held-low (break) line must go high before a new start is accepted.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed self-checking bench for uart_rx_byte at 100 MHz / 115200 baud.
module tb_uart_rx_byte;

  localparam int CPB      = 868;  // nominal clocks per bit
  localparam int CPB_FAST = 851;  // transmitter at 117504 baud
  localparam int CPB_SLOW = 886;  // transmitter at 112896 baud

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  int         cyc = 0;
  int         n_valid = 0;
  int         last_valid_cyc = 0;
  int         run_len = 0;
  bit         long_pulse = 1'b0;
  logic [7:0] got_q[$];

  uart_rx_byte #(
    .sys_clk_freq(100000000),
    .baud_rate   (115200)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Output monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      got_q.push_back(rx_byte);
      run_len++;
      if (run_len > 1) long_pulse = 1'b1;
    end else begin
      run_len = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drives one 8N1 frame, LSB first, cpb clocks per bit; the line is left
  // at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int cpb);
    rx = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (cpb) @(negedge clk);
      if (i == 3) check("busy_mid_frame", busy, 1'b1);
    end
    rx = stop_bit;
    repeat (cpb) @(negedge clk);
  endtask

  initial begin
    int start_cyc;
    int nv;
    int lat;
    logic [7:0] b5a;

    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_rx_byte",   rx_byte,   8'h00);
    check("rst_rx_valid",  rx_valid,  1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy",      busy,      1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Basic frame 0xA5 with latency measurement.
    nv = n_valid;
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, CPB);
    repeat (10) @(negedge clk);
    lat = last_valid_cyc - start_cyc;
    check("a5_valid_count", n_valid - nv, 1);
    check("a5_byte",        rx_byte,      8'hA5);
    check("a5_frame_err",   frame_err,    1'b0);
    check("a5_busy_after",  busy,         1'b0);
    check("a5_latency_8240_8260", (lat >= 8240 && lat <= 8260), 1'b1);

    // 300-cycle glitch on an idle line.
    nv = n_valid;
    rx = 1'b0;
    repeat (300) @(negedge clk);
    rx = 1'b1;
    repeat (140) @(negedge clk);
    check("glitch_busy_440", busy,         1'b0);
    check("glitch_no_valid", n_valid - nv, 0);
    check("glitch_byte",     rx_byte,      8'hA5);

    // 0x3C with a bad stop bit, line held low for two more bit times.
    nv = n_valid;
    send_frame(8'h3C, 1'b0, CPB);
    repeat (2 * CPB) @(negedge clk);
    check("ferr_flag",       frame_err,    1'b1);
    check("ferr_byte_kept",  rx_byte,      8'hA5);
    check("ferr_no_valid",   n_valid - nv, 0);
    check("ferr_busy_break", busy,         1'b1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("ferr_busy_released", busy, 1'b0);
    nv = n_valid;
    send_frame(8'h01, 1'b1, CPB);
    repeat (10) @(negedge clk);
    check("x01_byte",      rx_byte,      8'h01);
    check("x01_ferr_clr",  frame_err,    1'b0);
    check("x01_valid_cnt", n_valid - nv, 1);

    // Back-to-back 0x00 then 0xFF, no idle gap.
    got_q.delete();
    send_frame(8'h00, 1'b1, CPB);
    send_frame(8'hFF, 1'b1, CPB);
    repeat (10) @(negedge clk);
    check("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("b2b_first",  got_q[0], 8'h00);
      check("b2b_second", got_q[1], 8'hFF);
    end
    check("b2b_byte_now", rx_byte, 8'hFF);

    // Reset asserted mid data bit 4 of 0x5A, released during the stop bit.
    nv  = n_valid;
    b5a = 8'h5A;
    rx  = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b5a[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b5a[4];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_byte",  rx_byte,   8'h00);
    check("mid_rst_valid", rx_valid,  1'b0);
    check("mid_rst_ferr",  frame_err, 1'b0);
    check("mid_rst_busy",  busy,      1'b0);
    repeat (CPB - CPB / 2 - 1) @(negedge clk);
    for (int i = 5; i < 8; i++) begin
      rx = b5a[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB / 4) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB - CPB / 4) @(negedge clk);
    check("mid_rst_no_valid", n_valid - nv, 0);
    check("mid_rst_idle",     busy,         1'b0);
    check("mid_rst_byte_after", rx_byte,    8'h00);
    nv = n_valid;
    send_frame(8'h5A, 1'b1, CPB);
    repeat (10) @(negedge clk);
    check("x5a_byte",      rx_byte,      8'h5A);
    check("x5a_valid_cnt", n_valid - nv, 1);

    // Baud tolerance: transmitter at +2% and -2%.
    nv = n_valid;
    send_frame(8'h96, 1'b1, CPB_FAST);
    repeat (CPB) @(negedge clk);
    check("fast_byte",  rx_byte,      8'h96);
    check("fast_ferr",  frame_err,    1'b0);
    check("fast_valid", n_valid - nv, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    nv = n_valid;
    send_frame(8'h96, 1'b1, CPB_SLOW);
    repeat (10) @(negedge clk);
    check("slow_byte",  rx_byte,      8'h96);
    check("slow_ferr",  frame_err,    1'b0);
    check("slow_valid", n_valid - nv, 1);

    check("valid_one_cycle", long_pulse, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
